fir_decimate_out: RTL and testbench

- Sits directly downstream of the 32-tap FIR filter and consumes its 17-bit unsigned output stream.
- Keeps one of every DECIM qualified samples.
- Rounds and scales each kept sample to OUT_WIDTH bits, with saturation.
- Buffers results in a small first-word-fall-through FIFO with a valid/ready interface to the next stage.
- Flags dropped results with a sticky overflow bit.

---
 rtl/fir_decimate_out.sv | 161 ++++++++++++++++
 tb/tb_fir_decimate_out.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_decimate_out.sv
// fir_decimate_out
// Decimates the unsigned FIR output stream, rounds and saturates each kept
// sample to OUT_WIDTH bits, and queues results in a first-word-fall-through
// FIFO with a valid/ready interface.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset; clears all state
//   sample_in   filter output sample (unsigned, IN_WIDTH bits)
//   sample_en   sample_in carries a new filter sample this cycle
//   out_data    FIFO head value, meaningful while out_valid=1
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts out_data this cycle
//   fill_level  current FIFO occupancy, 0..FIFO_DEPTH
//   overflow    sticky flag: a result was dropped because the FIFO was full
//   clear_ovf   synchronous clear of overflow (a coincident drop wins)
module fir_decimate_out #(
  parameter int IN_WIDTH   = 17,
  parameter int OUT_WIDTH  = 8,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [IN_WIDTH-1:0]           sample_in,
  input  logic                          sample_en,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  input  logic                          clear_ovf
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int SUMW = IN_WIDTH + 1;

  localparam logic [PW-1:0]        PHASE_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]        PHASE_ONE  = PW'(1'b1);
  localparam logic [PW-1:0]        PHASE_LAST = PW'(DECIM - 1);
  localparam logic [SUMW-1:0]      ROUND_ADD  = SUMW'(1'b1) << (SHIFT - 1);
  localparam logic [OUT_WIDTH-1:0] OUT_MAX    = {OUT_WIDTH{1'b1}};
  localparam logic [SUMW-1:0]      SAT_LIM    = SUMW'(OUT_MAX);
  localparam logic [AW:0]          PTR_ONE    = (AW + 1)'(1'b1);

  // Round-half-up, shift and clamp; the sum carries one extra bit so it never wraps.
  function automatic logic [OUT_WIDTH-1:0] scale_sat(input logic [IN_WIDTH-1:0] x);
    logic [SUMW-1:0] sum_v;
    logic [SUMW-1:0] q_v;
    sum_v = {1'b0, x} + ROUND_ADD;
    q_v   = sum_v >> SHIFT;
    if (q_v > SAT_LIM) begin
      scale_sat = OUT_MAX;
    end else begin
      scale_sat = q_v[OUT_WIDTH-1:0];
    end
  endfunction

  logic [PW-1:0]        phase_r;
  logic                 keep_s;
  logic                 stage_vld_r;
  logic [OUT_WIDTH-1:0] stage_res_r;
  logic [OUT_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_r;
  logic [AW:0]          rd_ptr_r;

  logic                 pop_s;
  logic                 full_s;
  logic                 push_s;
  logic                 drop_s;
  logic [AW:0]          wr_nx_s;
  logic [AW:0]          rd_nx_s;
  logic [AW:0]          cnt_nx_s;
  logic [OUT_WIDTH-1:0] head_nx_s;

  assign keep_s = sample_en && (phase_r == PHASE_ZERO);

  // Decimation phase: advances on every qualified sample, independent of the FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_r <= PHASE_ZERO;
    end else if (sample_en) begin
      phase_r <= (phase_r == PHASE_LAST) ? PHASE_ZERO : phase_r + PHASE_ONE;
    end else begin
      phase_r <= phase_r;
    end
  end

  // Scale stage: captures the rounded/saturated result of a kept sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_vld_r <= 1'b0;
      stage_res_r <= {OUT_WIDTH{1'b0}};
    end else begin
      stage_vld_r <= keep_s;
      if (keep_s) begin
        stage_res_r <= scale_sat(sample_in);
      end else begin
        stage_res_r <= stage_res_r;
      end
    end
  end

  // FIFO control: push/pop decisions and next-state pointers and head value.
  always_comb begin
    pop_s     = out_valid && out_ready;
    full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    push_s    = stage_vld_r && (!full_s || pop_s);
    drop_s    = stage_vld_r && full_s && !pop_s;
    wr_nx_s   = push_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
    rd_nx_s   = pop_s  ? rd_ptr_r + PTR_ONE : rd_ptr_r;
    cnt_nx_s  = wr_nx_s - rd_nx_s;
    // The new head is the entry being written only when the FIFO drains to it.
    if (push_s && (wr_ptr_r[AW-1:0] == rd_nx_s[AW-1:0])) begin
      head_nx_s = stage_res_r;
    end else begin
      head_nx_s = mem_r[rd_nx_s[AW-1:0]];
    end
  end

  // FIFO storage: data only, pointers define what is live.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= stage_res_r;
    end
  end

  // FIFO pointers and registered output view (head, valid, occupancy, overflow).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= {(AW + 1){1'b0}};
      rd_ptr_r   <= {(AW + 1){1'b0}};
      fill_level <= {(AW + 1){1'b0}};
      out_valid  <= 1'b0;
      out_data   <= {OUT_WIDTH{1'b0}};
      overflow   <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_nx_s;
      rd_ptr_r   <= rd_nx_s;
      fill_level <= cnt_nx_s;
      out_valid  <= (cnt_nx_s != {(AW + 1){1'b0}});
      if (cnt_nx_s != {(AW + 1){1'b0}}) begin
        out_data <= head_nx_s;
      end else begin
        out_data <= out_data;
      end
      if (drop_s) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end else begin
        overflow <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_fir_decimate_out.sv
// Self-checking bench for fir_decimate_out: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_fir_decimate_out;

  localparam int DECIM   = 4;
  localparam int SHIFT   = 8;
  localparam int DEPTH   = 4;
  localparam int OUT_MAX = 255;

  logic        clock = 1'b0;
  logic        reset;
  logic [16:0] sample_in;
  logic        sample_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fill_level;
  logic        overflow;
  logic        clear_ovf;

  fir_decimate_out #(
    .IN_WIDTH(17), .OUT_WIDTH(8), .DECIM(DECIM), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .sample_in(sample_in), .sample_en(sample_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill_level(fill_level), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int mq[$];
  bit pend_v;
  int pend_d;
  int en_cnt;
  bit m_ovf;
  int m_last;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int ref_scale(input int x);
    int q;
    q = (x + 2 ** (SHIFT - 1)) / (2 ** SHIFT);
    return (q > OUT_MAX) ? OUT_MAX : q;
  endfunction

  task automatic model_reset();
    mq.delete();
    pend_v = 1'b0;
    pend_d = 0;
    en_cnt = 0;
    m_ovf  = 1'b0;
    m_last = 0;
  endtask

  task automatic model_edge(input bit en, input int d, input bit rdy, input bit clr);
    bit drop;
    drop = 1'b0;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (pend_v) begin
      if (mq.size() < DEPTH) mq.push_back(pend_d);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    pend_v = en && (en_cnt % DECIM == 0);
    pend_d = ref_scale(d);
    if (en) en_cnt++;
    if (mq.size() > 0) m_last = mq[0];
  endtask

  task automatic check_outputs();
    check_eq("out_valid", int'(out_valid), int'(mq.size() > 0));
    check_eq("fill_level", int'(fill_level), mq.size());
    check_eq("overflow", int'(overflow), int'(m_ovf));
    check_eq("out_data", int'(out_data), m_last);
  endtask

  task automatic cyc(input bit en, input int d, input bit rdy, input bit clr);
    sample_en = en;
    sample_in = 17'(d);
    out_ready = rdy;
    clear_ovf = clr;
    @(posedge clock);
    if (reset) model_edge(en, d, rdy, clr);
    #1;
    check_outputs();
  endtask

  task automatic align(input bit rdy);
    while (en_cnt % DECIM != 0) cyc(1'b1, 0, rdy, 1'b0);
  endtask

  initial begin
    int rvals[5];
    int rexp[5];
    int dexp[4];
    rvals = '{32'h7F, 32'h80, 32'hFF7F, 32'hFF80, 32'h1FFFF};
    rexp  = '{0, 1, 255, 255, 255};
    dexp  = '{2, 3, 4, 6};

    reset = 1'b0; sample_en = 1'b0; sample_in = 17'd0; out_ready = 1'b0; clear_ovf = 1'b0;
    model_reset();
    #1;
    check_outputs();
    #12 reset = 1'b1;

    // decimation by 4, first kept sample visible two cycles after presentation
    cyc(1'b1, 32'h180, 1'b1, 1'b0);
    check_eq("lat_not_yet", int'(out_valid), 0);
    cyc(1'b1, 32'h200, 1'b1, 1'b0);
    check_eq("lat_valid", int'(out_valid), 1);
    check_eq("lat_data", int'(out_data), 2);
    cyc(1'b1, 32'h300, 1'b1, 1'b0);
    cyc(1'b1, 32'h400, 1'b1, 1'b0);
    cyc(1'b1, 32'h080, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    check_eq("decim_second", int'(out_data), 1);
    cyc(1'b0, 0, 1'b1, 1'b0);

    // rounding and saturation boundaries
    align(1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, rvals[i], 1'b1, 1'b0);
      cyc(1'b1, 0, 1'b1, 1'b0);
      check_eq("round_sat", int'(out_data), rexp[i]);
      cyc(1'b1, 0, 1'b1, 1'b0);
      cyc(1'b1, 0, 1'b1, 1'b0);
    end

    // backpressure: four fill the FIFO, the fifth is dropped
    align(1'b1);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, k * 256, 1'b0, 1'b0);
      for (int j = 0; j < 3; j++) cyc(1'b1, 0, 1'b0, 1'b0);
    end
    check_eq("bp_fill", int'(fill_level), 4);
    check_eq("bp_ovf", int'(overflow), 1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    check_eq("ovf_clear1", int'(overflow), 0);
    // push and pop together while full
    cyc(1'b1, 6 * 256, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b1, 1'b0);
    check_eq("full_pp_fill", int'(fill_level), 4);
    check_eq("full_pp_ovf", int'(overflow), 0);
    cyc(1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b0, 1'b0);
    // drop coinciding with clear: set wins
    cyc(1'b1, 7 * 256, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b0, 1'b1);
    check_eq("ovf_set_wins", int'(overflow), 1);
    cyc(1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1);
    check_eq("ovf_clear2", int'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_data", int'(out_data), dexp[i]);
      cyc(1'b0, 0, 1'b1, 1'b0);
    end
    check_eq("drain_empty", int'(out_valid), 0);

    // sample_en gaps: phase only moves on qualified samples
    align(1'b1);
    for (int i = 0; i < 24; i++) begin
      cyc(1'b1, int'($urandom_range(0, 32'h1FFFF)), 1'b1, 1'b0);
      cyc(1'b0, int'($urandom_range(0, 32'h1FFFF)), 1'b1, 1'b0);
      cyc(1'b0, int'($urandom_range(0, 32'h1FFFF)), 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 1'b0);

    // asynchronous reset mid-stream with FIFO at 3 entries and stage valid
    align(1'b1);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b1, k * 300, 1'b0, 1'b0);
      for (int j = 0; j < 3; j++) cyc(1'b1, 0, 1'b0, 1'b0);
    end
    cyc(1'b1, 32'h500, 1'b0, 1'b0);
    check_eq("pre_rst_fill", int'(fill_level), 3);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_fill", int'(fill_level), 0);
    check_eq("rst_ovf", int'(overflow), 0);
    check_eq("rst_data", int'(out_data), 0);
    @(posedge clock);
    #3 reset = 1'b1;
    cyc(1'b1, 32'h200, 1'b1, 1'b0);
    cyc(1'b1, 0, 1'b1, 1'b0);
    check_eq("post_rst_valid", int'(out_valid), 1);
    check_eq("post_rst_data", int'(out_data), 2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 32'h1FFFF)),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
